opb_master_arbiter: RTL
=======================

# opb_master_arbiter

Round-robin OPB master controller that shares one OPB master port between `C_NREQ` internal requesters: software-side bridges, DMA sequencers and the counter-snapshot logic that reads register slaves such as the gbe tx/rx counters. It sits between the requesters and the OPB bus in the ROACH2 base system. Per transaction it:
- grants one requester;
- runs a single OPB read or write;
- handles `xferAck`, `errAck`, `retry` and timeout;
- returns the response to the granted requester only.

## Interface
Parameters:
- `C_NREQ`, 4: number of requesters, 2..8
- `C_OPB_AWIDTH`, 32: address width
- `C_OPB_DWIDTH`, 32: data width
- `C_TIMEOUT`, 16: bus cycles without acknowledge before the arbiter aborts, 2..255
- `C_MAX_RETRY`, 3: re-issues allowed after `OPB_retry` before an error is reported

Ports:
- `OPB_Clk`  in  1  single clock for all logic
- `OPB_Rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  C_NREQ  per-requester request; held until `req_ready`
- `req_rnw`  in  C_NREQ  1 = read, 0 = write
- `req_addr`  in  C_NREQ*C_OPB_AWIDTH  flattened; requester i at bits [i*AW +: AW]
- `req_wdata`  in  C_NREQ*C_OPB_DWIDTH  flattened write data
- `req_be`  in  C_NREQ*4  flattened byte enables
- `req_ready`  out  C_NREQ  one-hot, one-cycle acceptance pulse
- `rsp_valid`  out  C_NREQ  one-hot, one-cycle completion pulse
- `rsp_rdata`  out  C_OPB_DWIDTH  read data, shared; valid with `rsp_valid`
- `rsp_err`  out  1  error flag, valid with `rsp_valid`
- `M_ABus`, `M_DBus`  out  32 each  OPB address and write data; zero when not selected
- `M_BE`  out  4  OPB byte enables; zero when not selected
- `M_RNW`, `M_select`, `M_seqAddr`  out  1 each  OPB control; `M_seqAddr` is always 0
- `OPB_DBus`  in  32  OR-ed slave read data
- `OPB_xferAck`, `OPB_errAck`, `OPB_retry`, `OPB_toutSup`  in  1 each  slave responses
- `stat_xfer_cnt`, `stat_err_cnt`  out  32 each  statistics counters (see Configuration)

## Operation
State machine: IDLE, BUS, BACKOFF, RESP.

- **IDLE**
  - If any `req_valid` is high, choose the first requester searching from `last_grant+1` modulo `C_NREQ`.
  - Latch its `rnw`, `addr`, `wdata` and `be`; pulse its `req_ready`; clear the timeout and retry counters; go to BUS.
- **BUS**
  - `M_select`=1 and the latched fields are driven onto the bus.
  - `OPB_errAck` → `err`=1, capture `OPB_DBus`, go to RESP. `errAck` takes priority over `xferAck` when both are high.
  - `OPB_xferAck` → `err`=0, capture `OPB_DBus` (reads only; writes capture 0), go to RESP.
  - `OPB_retry` with no ack:
    - retry count < `C_MAX_RETRY`: increment it, go to BACKOFF;
    - otherwise: `err`=1, `rdata`=0, go to RESP.
  - Otherwise the timeout counter increments, except it holds while `OPB_toutSup`=1. When it reaches `C_TIMEOUT`: `err`=1, `rdata`=0, go to RESP.
- **BACKOFF**: `M_select`=0 for exactly one cycle; clear the timeout counter; return to BUS with the same requester.
- **RESP**: pulse `rsp_valid[grant]` with `rsp_rdata`/`rsp_err`; set `last_grant` = grant; go to IDLE.
- `req_valid` changes on non-granted requesters never affect a transaction in flight.

## Timing
- All outputs register on `OPB_Clk`. Reset clears them immediately to 0.
- After reset, the state is IDLE and `last_grant` = `C_NREQ-1`, so requester 0 has first priority.
- Asserting `OPB_Rst_n` low mid-transaction:
  - drops `M_select` asynchronously;
  - discards the transaction; no `rsp_valid` is produced.
- Latency, with `req_valid` sampled high at cycle 0:
  - `req_ready` at cycle 0, combinationally from IDLE, registered request-side;
  - `M_select` from cycle 1;
  - fastest `xferAck` at cycle 1 gives `rsp_valid` at cycle 2;
  - `M_select` deasserts the cycle after the acknowledge.
- Back-to-back throughput: one transaction per 3 cycles minimum (IDLE, BUS, RESP).
- A timeout with no acknowledge gives `rsp_valid` exactly `C_TIMEOUT+1` cycles after `M_select` rises, excluding `toutSup` cycles.

## Configuration
- `OPB_ARB_STATS_EN` defined:
  - `stat_xfer_cnt` increments on every RESP;
  - `stat_err_cnt` increments on every RESP with `err`=1;
  - both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Not defined: both counters are tied to 0 and their registers are removed.

## Test plan
- **Single read.** Requester 2 reads 0x01080400; the slave returns 0xDEADBEEF with `xferAck` on the 2nd BUS cycle → `rsp_valid`=0b0100, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `M_ABus`=0x01080400 while selected.
- **Round-robin fairness.** All 4 requesters hold `req_valid` from reset; every slave acks immediately → grant order is 0,1,2,3,0; no requester is granted twice before all are served.
- **Retry then success.** `OPB_retry` on the first 2 attempts, `xferAck` on the 3rd → two BACKOFF cycles with `M_select`=0, one `rsp_valid` with `err`=0. With 4 retries and `C_MAX_RETRY`=3 → `rsp_err`=1, `rdata`=0.
- **Timeout and toutSup.** No ack with `C_TIMEOUT`=16 → `rsp_err`=1 at select+17 cycles. With `toutSup` high for 10 of those cycles → the response moves to select+27.
- **errAck and xferAck together, plus reset mid-operation.** Simultaneous `errAck`/`xferAck` → `rsp_err`=1. `OPB_Rst_n` pulsed low during BUS → `M_select` drops at once, no `rsp_valid`, and the next grant goes to requester 0.
- **Statistics.** With `OPB_ARB_STATS_EN`: 5 transactions, of which 2 are errors → `stat_xfer_cnt`=5, `stat_err_cnt`=2. Without the macro → both read 0.

Source files
------------

// File: rtl/opb_master_arbiter.sv
// Round-robin controller sharing one OPB master port among C_NREQ requesters.
// Define OPB_ARB_STATS_EN to build the transfer/error statistics counters.
module opb_master_arbiter #(
   parameter int C_NREQ       = 4,
   parameter int C_OPB_AWIDTH = 32,
   parameter int C_OPB_DWIDTH = 32,
   parameter int C_TIMEOUT    = 16,
   parameter int C_MAX_RETRY  = 3
) (
   input  logic                             OPB_Clk,
   input  logic                             OPB_Rst_n,
   input  logic [C_NREQ-1:0]                req_valid,
   input  logic [C_NREQ-1:0]                req_rnw,
   input  logic [C_NREQ*C_OPB_AWIDTH-1:0]   req_addr,
   input  logic [C_NREQ*C_OPB_DWIDTH-1:0]   req_wdata,
   input  logic [C_NREQ*4-1:0]              req_be,
   output logic [C_NREQ-1:0]                req_ready,
   output logic [C_NREQ-1:0]                rsp_valid,
   output logic [C_OPB_DWIDTH-1:0]          rsp_rdata,
   output logic                             rsp_err,
   output logic [C_OPB_AWIDTH-1:0]          M_ABus,
   output logic [C_OPB_DWIDTH-1:0]          M_DBus,
   output logic [3:0]                       M_BE,
   output logic                             M_RNW,
   output logic                             M_select,
   output logic                             M_seqAddr,
   input  logic [C_OPB_DWIDTH-1:0]          OPB_DBus,
   input  logic                             OPB_xferAck,
   input  logic                             OPB_errAck,
   input  logic                             OPB_retry,
   input  logic                             OPB_toutSup,
   output logic [31:0]                      stat_xfer_cnt,
   output logic [31:0]                      stat_err_cnt
);

   localparam int GW = (C_NREQ > 1) ? $clog2(C_NREQ) : 1;

   typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

   state_t                  state, next_state;
   logic [GW-1:0]           grant, last_grant, sel_idx, rr_idx;
   logic                    sel_found;
   int unsigned             rr_pos;
   logic                    sel_rnw, lat_rnw;
   logic [C_OPB_AWIDTH-1:0] sel_addr, lat_addr;
   logic [C_OPB_DWIDTH-1:0] sel_wdata, lat_wdata;
   logic [3:0]              sel_be, lat_be;
   logic [7:0]              tout_cnt, retry_cnt;
   logic                    tout_inc, tout_clr, retry_inc, retry_clr;
   logic                    rsp_err_d;
   logic [C_OPB_DWIDTH-1:0] rsp_rdata_d;

   // Search for the first valid requester starting just after the last one served.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      rr_pos    = 0;
      rr_idx    = '0;
      for (int i = 0; i < C_NREQ; i++) begin
         rr_pos = (int'(last_grant) + 1 + i) % C_NREQ;
         rr_idx = GW'(rr_pos);
         if (!sel_found && req_valid[rr_idx]) begin
            sel_found = 1'b1;
            sel_idx   = rr_idx;
         end
      end
   end

   assign sel_rnw   = req_rnw[sel_idx];
   assign sel_addr  = req_addr[int'(sel_idx)*C_OPB_AWIDTH +: C_OPB_AWIDTH];
   assign sel_wdata = req_wdata[int'(sel_idx)*C_OPB_DWIDTH +: C_OPB_DWIDTH];
   assign sel_be    = req_be[int'(sel_idx)*4 +: 4];
   assign M_seqAddr = 1'b0;

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) state <= IDLE;
      else            state <= next_state;
   end

   always_comb begin
      next_state  = state;
      req_ready   = '0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      tout_inc    = 1'b0;
      tout_clr    = 1'b0;
      retry_inc   = 1'b0;
      retry_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (sel_found) begin
               req_ready[sel_idx] = 1'b1;
               tout_clr           = 1'b1;
               retry_clr          = 1'b1;
               next_state         = BUS;
            end
         end
         BUS: begin
            // errAck wins over xferAck; retry only counts when neither ack is present.
            if (OPB_errAck) begin
               rsp_err_d   = 1'b1;
               rsp_rdata_d = OPB_DBus;
               next_state  = RESP;
            end else if (OPB_xferAck) begin
               rsp_rdata_d = lat_rnw ? OPB_DBus : '0;
               next_state  = RESP;
            end else if (OPB_retry) begin
               if (retry_cnt < 8'(C_MAX_RETRY)) begin
                  retry_inc  = 1'b1;
                  next_state = BACKOFF;
               end else begin
                  rsp_err_d  = 1'b1;
                  next_state = RESP;
               end
            end else if (!OPB_toutSup) begin
               if (tout_cnt == 8'(C_TIMEOUT)) begin
                  rsp_err_d  = 1'b1;
                  next_state = RESP;
               end else begin
                  tout_inc = 1'b1;
               end
            end
         end
         BACKOFF: begin
            tout_clr   = 1'b1;
            next_state = BUS;
         end
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Bus-side outputs are registered from next_state so M_select follows the FSM by one edge.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         grant      <= '0;
         last_grant <= GW'(C_NREQ - 1);
         lat_rnw    <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_be     <= '0;
         tout_cnt   <= '0;
         retry_cnt  <= '0;
         M_select   <= 1'b0;
         M_RNW      <= 1'b0;
         M_ABus     <= '0;
         M_DBus     <= '0;
         M_BE       <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         if (state == IDLE && sel_found) begin
            grant     <= sel_idx;
            lat_rnw   <= sel_rnw;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_be    <= sel_be;
         end
         if (tout_clr)      tout_cnt <= '0;
         else if (tout_inc) tout_cnt <= tout_cnt + 8'd1;
         if (retry_clr)      retry_cnt <= '0;
         else if (retry_inc) retry_cnt <= retry_cnt + 8'd1;
         if (state == RESP) last_grant <= grant;

         M_select <= (next_state == BUS);
         if (next_state == BUS) begin
            M_RNW  <= (state == IDLE) ? sel_rnw   : lat_rnw;
            M_ABus <= (state == IDLE) ? sel_addr  : lat_addr;
            M_DBus <= (state == IDLE) ? sel_wdata : lat_wdata;
            M_BE   <= (state == IDLE) ? sel_be    : lat_be;
         end else begin
            M_RNW  <= 1'b0;
            M_ABus <= '0;
            M_DBus <= '0;
            M_BE   <= '0;
         end

         rsp_valid <= '0;
         if (next_state == RESP) rsp_valid[grant] <= 1'b1;
         rsp_rdata <= rsp_rdata_d;
         rsp_err   <= rsp_err_d;
      end
   end

`ifdef OPB_ARB_STATS_EN
   logic [31:0] xfer_cnt, err_cnt;

   // Saturating counters sampled while the response is presented.
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         xfer_cnt <= '0;
         err_cnt  <= '0;
      end else if (state == RESP) begin
         if (xfer_cnt != 32'hFFFF_FFFF) xfer_cnt <= xfer_cnt + 32'd1;
         if (rsp_err && err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
      end
   end

   assign stat_xfer_cnt = xfer_cnt;
   assign stat_err_cnt  = err_cnt;
`else
   assign stat_xfer_cnt = '0;
   assign stat_err_cnt  = '0;
`endif

endmodule
